// File: rtl/accum_pkg.sv
// Shared encodings for the accumulator UART readout: FSM states and 8N1 frame constants.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick_o marks the last cycle of each CLKS_PER_BIT_P-cycle bit.
// Count is held at 0 while en_i is low so every frame starts on a fresh bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT_P = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT_P > 1) ? $clog2(CLKS_PER_BIT_P) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT_P - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/accum_uart_tx.sv
// Snapshots the accumulator word on send_i and shifts it out as 8N1 frames, LS byte first.
// tx_o/busy_o change on the accepting edge; send_i is ignored (not queued) while busy.
module accum_uart_tx
  import accum_pkg::*;
#(
  parameter int WIDTH_P        = 8,
  parameter int CLKS_PER_BIT_P = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               send_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               tx_o
);

  localparam int NUM_BYTES = WIDTH_P / 8;
  localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e          state_q, state_d;
  logic [WIDTH_P-1:0] shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick;

  uart_baud_gen #(
    .CLKS_PER_BIT_P(CLKS_PER_BIT_P)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  // tx_d is the level for the next bit, so tx_o is a flop and lines up with the state change.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = STOP_LVL;
        if (send_i) begin
          shift_d    = data_i;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = START_LVL;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            tx_d    = STOP_LVL;
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            tx_d       = START_LVL;
            state_d    = ST_START;
          end else begin
            tx_d    = STOP_LVL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_q       <= STOP_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/accum_uart_tx.md
# accum_uart_tx

Serial readout stage directly downstream of the accumulator. On request it snapshots the accumulator's output word and sends it on a single UART TX line: 8N1 frames, LSB first, least-significant byte first. This lets the accumulated value leave the chip on one output pin.

## Interface

Parameters:
- `WIDTH_P`, default 8: width of the accumulated word; must be a multiple of 8. `NUM_BYTES = WIDTH_P/8`.
- `CLKS_PER_BIT_P`, default 16: clock cycles per UART bit; must be at least 2.

Ports:
- `clk_i`  in  1: clock. The block has one clock.
- `rst_ni`  in  1: reset, asynchronous and active-low.
- `data_i`  in  `WIDTH_P`: accumulator output word.
- `send_i`  in  1: transmit request, level-sampled.
- `busy_o`  out  1: high while a word is being sent.
- `done_o`  out  1: one-cycle pulse after the last stop bit of a word.
- `tx_o`  out  1: UART serial line; idles high.

## Operation

- FSM states are IDLE, START, DATA, STOP.
- **IDLE**
  - `tx_o` = 1.
  - If `send_i` = 1 at a clock edge, `data_i` is captured into the shift register, the byte counter is cleared, and the FSM moves to START.
- **START**
  - `tx_o` = 0 for `CLKS_PER_BIT_P` cycles.
  - Then the FSM moves to DATA with the bit counter at 0.
- **DATA**
  - `tx_o` = shift register bit 0 for `CLKS_PER_BIT_P` cycles.
  - The register then shifts right by 1.
  - After 8 bits the FSM moves to STOP.
- **STOP**
  - `tx_o` = 1 for `CLKS_PER_BIT_P` cycles.
  - If the byte counter is below `NUM_BYTES-1`, the counter increments and the FSM returns to START with the next byte.
  - Otherwise the FSM moves to IDLE and `done_o` pulses.
- The snapshot is fixed for the whole transfer. Changes on `data_i` during `busy_o` have no effect.
- `send_i` is ignored while busy. Requests are not queued.
- `send_i` held high gives back-to-back words separated by exactly one idle-high cycle.
- A zero word is transmitted normally; there is no suppression.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing

- **Reset values:** `tx_o` = 1, `busy_o` = 0, `done_o` = 0, FSM = IDLE, all counters = 0.
- **Reset during a transfer:** asserting `rst_ni` low at any time forces the reset values immediately.
  - The word in flight is aborted and no `done_o` pulse is produced.
  - After release, the first accepted `send_i` starts a clean frame.
- **Acceptance:** `send_i` sampled high at edge N in IDLE. `tx_o` = 0 and `busy_o` = 1 take effect from edge N.
- **Word duration:** `busy_o` stays high for exactly `NUM_BYTES*10*CLKS_PER_BIT_P` cycles.
- **End of word:**
  - `busy_o` falls and `done_o` rises on the same edge; `done_o` is high for exactly 1 cycle.
  - `send_i` high in that cycle is accepted, so the word period is `NUM_BYTES*10*CLKS_PER_BIT_P + 1` cycles.
- **Bit timing:**
  - The baud counter runs from 0 to `CLKS_PER_BIT_P-1` and wraps to 0 at each bit boundary.
  - It is held at 0 in IDLE.
  - The counter width is `$clog2(CLKS_PER_BIT_P)`.
- **Counter widths:** the bit counter is 3 bits. The byte counter is `$clog2(NUM_BYTES)` bits, with a minimum of 1.

## Structure

- Shared package `accum_pkg` holds:
  - the FSM state encoding (2-bit IDLE/START/DATA/STOP);
  - the UART frame constants: start level 0, stop level 1, 8 data bits, 10 bits per frame.
- Sub-module `uart_baud_gen`:
  - parameter `CLKS_PER_BIT_P`; inputs `clk_i`, `rst_ni`, `en_i`;
  - output `tick_o` pulses on the last cycle of each bit period;
  - it is held at count 0 when `en_i` = 0.
- The top level holds the FSM, the shift register, and the bit and byte counters.

## Test plan

- **Reset:** assert `rst_ni` low with `send_i` = 1. Require `tx_o` = 1, `busy_o` = 0, `done_o` = 0 throughout, and no transmission until release.
- **Single byte** (`WIDTH_P` = 8, `CLKS_PER_BIT_P` = 4): `data_i` = 0xA5 with a 1-cycle `send_i` pulse.
  - `tx_o` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - `busy_o` high for 40 cycles, then a single `done_o` pulse.
- **Snapshot:** send 0x3C, then change `data_i` to 0xFF at cycle 10 of the frame. Require the serial data to decode as 0x3C.
- **Back-to-back:** hold `send_i` = 1 with `data_i` = 0x01. Require frames repeating every 41 cycles, with one idle-high cycle coinciding with each `done_o`.
- **Multi-byte** (`WIDTH_P` = 16): `data_i` = 0x1234. Require byte 0x34 then byte 0x12, `busy_o` for 80 cycles, and exactly one `done_o` pulse.
- **Abort:** pull `rst_ni` low at cycle 15 of a frame. Require `tx_o` = 1 and `busy_o` = 0 immediately, no `done_o` pulse, and a subsequent send of 0x5A transmitted correctly.
